// File: rtl/acc_cpu_param_if.sv
// acc_cpu_param_if: program-load and debug-read port of the accumulator core.
// master drives prog_we/prog_addr/prog_data/dbg_addr; slave returns dbg_rdata.
interface acc_cpu_param_if #(
  parameter int DATA_W = 32,
  parameter int OPND_W = 16,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 4
);
  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [OPND_W+2:0] prog_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;

  modport master (
    output prog_we, prog_addr, prog_data, dbg_addr,
    input  dbg_rdata
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, dbg_addr,
    output dbg_rdata
  );
endinterface

// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised single-accumulator core with run-control FSM.
// Ports: clk, rst (sync, active-high), start pulse, io (program load +
// debug dmem read), pc, acc, busy, halted, retired instruction count.
module acc_cpu_param #(
  parameter int DATA_W = 32,
  parameter int OPND_W = 16,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  acc_cpu_param_if.slave    io,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);
  localparam int INSTR_W = OPND_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_ADD   = 3'b001,
    OP_STORE = 3'b010,
    OP_BRZ   = 3'b011,
    OP_SUB   = 3'b100,
    OP_LOADI = 3'b101,
    OP_JMP   = 3'b110,
    OP_HALT  = 3'b111
  } op_t;

  state_t state;

  logic [INSTR_W-1:0] imem [2**PC_W];
  logic [DATA_W-1:0]  dmem [2**ADDR_W];

  logic [INSTR_W-1:0] instr;
  op_t                op;
  logic [OPND_W-1:0]  opnd;
  logic [ADDR_W-1:0]  a;
  logic [PC_W-1:0]    t;
  logic [DATA_W-1:0]  rd;
  logic [PC_W-1:0]    pc_inc;

  assign instr  = imem[pc];
  assign op     = op_t'(instr[2:0]);
  assign opnd   = instr[INSTR_W-1:3];
  assign a      = opnd[ADDR_W-1:0];
  assign t      = opnd[PC_W-1:0];
  assign rd     = dmem[a];
  assign pc_inc = pc + PC_W'(1);

  assign io.dbg_rdata = dmem[io.dbg_addr];

  assign busy   = (state == S_RUN);
  assign halted = (state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      acc     <= '0;
      retired <= '0;
    end else if (state == S_RUN) begin
      if (retired != '1)
        retired <= retired + CNT_W'(1);
      pc <= pc_inc;
      unique case (op)
        OP_LOAD:  acc <= rd;
        OP_ADD:   acc <= acc + rd;
        OP_STORE: dmem[a] <= acc;
        OP_BRZ:   if (acc == '0) pc <= t;
        OP_SUB:   acc <= acc - rd;
        OP_LOADI: acc <= DATA_W'(opnd);
        OP_JMP:   pc <= t;
        OP_HALT: begin
          pc    <= pc;
          state <= S_HALTED;
        end
      endcase
    end else begin
      // Write lands on the start edge too, so the first fetch sees it.
      if (io.prog_we)
        imem[io.prog_addr] <= io.prog_data;
      if (start) begin
        state   <= S_RUN;
        pc      <= '0;
        acc     <= '0;
        retired <= '0;
      end
    end
  end
endmodule

// File: tb/tb_acc_cpu_param.sv
// tb_acc_cpu_param: directed-vector bench for acc_cpu_param.
// Each task drives one scenario and checks results inline.
module tb_acc_cpu_param;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  pc;
  logic [31:0] acc;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acc_cpu_param_if #(
    .DATA_W(32), .OPND_W(16), .ADDR_W(4), .PC_W(4)
  ) io ();

  acc_cpu_param #(
    .DATA_W(32), .OPND_W(16), .ADDR_W(4), .PC_W(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .io(io),
    .pc(pc), .acc(acc), .busy(busy), .halted(halted),
    .retired(retired)
  );

  localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, STORE = 3'd2;
  localparam logic [2:0] BRZ = 3'd3, SUB = 3'd4, LOADI = 3'd5;
  localparam logic [2:0] JMP = 3'd6, HALT = 3'd7;

  function automatic logic [18:0] enc(input logic [2:0] op,
                                      input logic [15:0] v);
    return {v, op};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic prog(input int ad, input logic [18:0] w);
    io.prog_we   = 1'b1;
    io.prog_addr = ad[3:0];
    io.prog_data = w;
    tick();
    io.prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (halted) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 4'd0) begin
      errors++; $display("FAIL reset_pc: got %h want 0", pc);
    end
    checks++;
    if (acc !== 32'd0) begin
      errors++; $display("FAIL reset_acc: got %h want 0", acc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL reset_halted: got %b want 0", halted);
    end
    checks++;
    if (retired !== 16'd0) begin
      errors++; $display("FAIL reset_retired: got %0d want 0", retired);
    end
  endtask

  // Seed dmem: d[3]=7, d[0]=1, d[5]=0xFFFFFFFF
  task automatic test_setup();
    bit ok;
    prog(0, enc(LOADI, 16'd7));
    prog(1, enc(STORE, 16'd3));
    prog(2, enc(LOADI, 16'd1));
    prog(3, enc(STORE, 16'd0));
    prog(4, enc(LOADI, 16'd0));
    prog(5, enc(SUB, 16'd0));
    prog(6, enc(STORE, 16'd5));
    prog(7, enc(HALT, 16'd0));
    pulse_start();
    run_to_halt(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL setup_timeout: halted=%b want 1", halted);
    end
    io.dbg_addr = 4'd3; #1;
    checks++;
    if (io.dbg_rdata !== 32'd7) begin
      errors++; $display("FAIL setup_d3: got %h want 7", io.dbg_rdata);
    end
    io.dbg_addr = 4'd5; #1;
    checks++;
    if (io.dbg_rdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL setup_d5: got %h want ffffffff", io.dbg_rdata);
    end
    checks++;
    if (retired !== 16'd8) begin
      errors++; $display("FAIL setup_retired: got %0d want 8", retired);
    end
  endtask

  task automatic test_add_store();
    bit ok;
    prog(0, enc(LOADI, 16'd5));
    prog(1, enc(ADD, 16'd3));
    prog(2, enc(STORE, 16'd4));
    prog(3, enc(HALT, 16'd0));
    pulse_start();
    run_to_halt(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL add_timeout: halted=%b want 1", halted);
    end
    io.dbg_addr = 4'd4; #1;
    checks++;
    if (io.dbg_rdata !== 32'd12) begin
      errors++; $display("FAIL add_d4: got %h want c", io.dbg_rdata);
    end
    checks++;
    if (acc !== 32'd12) begin
      errors++; $display("FAIL add_acc: got %h want c", acc);
    end
    checks++;
    if (retired !== 16'd4) begin
      errors++; $display("FAIL add_retired: got %0d want 4", retired);
    end
    checks++;
    if (pc !== 4'd3) begin
      errors++; $display("FAIL add_pc: got %0d want 3", pc);
    end
  endtask

  task automatic test_brz_sub();
    bit ok;
    prog(0, enc(LOADI, 16'd0));
    prog(1, enc(BRZ, 16'd3));
    prog(2, enc(LOADI, 16'd9));
    prog(3, enc(SUB, 16'd0));
    prog(4, enc(HALT, 16'd0));
    pulse_start();
    run_to_halt(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL brz_timeout: halted=%b want 1", halted);
    end
    checks++;
    if (acc !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL brz_acc: got %h want ffffffff", acc);
    end
    checks++;
    if (retired !== 16'd4) begin
      errors++; $display("FAIL brz_retired: got %0d want 4", retired);
    end
    checks++;
    if (pc !== 4'd4) begin
      errors++; $display("FAIL brz_pc: got %0d want 4", pc);
    end
  endtask

  task automatic test_jmp_loop();
    int bad = 0;
    prog(0, enc(LOADI, 16'd1));
    prog(1, enc(JMP, 16'd0));
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin
        io.prog_we   = 1'b1;
        io.prog_addr = 4'd1;
        io.prog_data = enc(HALT, 16'd0);
        start        = 1'b1;
      end
      tick();
      io.prog_we = 1'b0;
      start      = 1'b0;
      checks++;
      if (busy !== 1'b1 || pc !== 4'(k % 2)) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL loop_k%0d: busy=%b pc=%0d want busy=1 pc=%0d",
                   k, busy, pc, k % 2);
      end
    end
    checks++;
    if (retired !== 16'd20) begin
      errors++; $display("FAIL loop_retired: got %0d want 20", retired);
    end
    do_reset();
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL loop_rst: busy=%b halted=%b want 0 0", busy, halted);
    end
    pulse_start();
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || pc !== 4'd1) begin
      errors++; $display("FAIL loop_imem: busy=%b pc=%0d want 1 1", busy, pc);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < 16; i++)
      prog(i, enc(LOADI, 16'(i + 1)));
    pulse_start();
    repeat (16) tick();
    checks++;
    if (pc !== 4'd0 || acc !== 32'd16) begin
      errors++; $display("FAIL wrap_16: pc=%0d acc=%0d want 0 16", pc, acc);
    end
    tick();
    checks++;
    if (pc !== 4'd1 || acc !== 32'd1) begin
      errors++; $display("FAIL wrap_17: pc=%0d acc=%0d want 1 1", pc, acc);
    end
    do_reset();
    prog(0, enc(LOAD, 16'd5));
    prog(1, enc(ADD, 16'd0));
    prog(2, enc(HALT, 16'd0));
    pulse_start();
    run_to_halt(ok);
    checks++;
    if (!ok || acc !== 32'd0 || pc !== 4'd2) begin
      errors++;
      $display("FAIL add_wrap: ok=%b acc=%h pc=%0d want 1 0 2", ok, acc, pc);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    prog(1, enc(STORE, 16'd7));
    prog(2, enc(LOAD, 16'd7));
    prog(3, enc(ADD, 16'd7));
    prog(4, enc(HALT, 16'd0));
    io.prog_we   = 1'b1;
    io.prog_addr = 4'd0;
    io.prog_data = enc(LOADI, 16'h33);
    start        = 1'b1;
    tick();
    io.prog_we = 1'b0;
    start      = 1'b0;
    run_to_halt(ok);
    checks++;
    if (!ok || acc !== 32'h66) begin
      errors++; $display("FAIL b2b_acc: ok=%b acc=%h want 1 66", ok, acc);
    end
    io.dbg_addr = 4'd7; #1;
    checks++;
    if (io.dbg_rdata !== 32'h33) begin
      errors++; $display("FAIL b2b_d7: got %h want 33", io.dbg_rdata);
    end
    checks++;
    if (retired !== 16'd5) begin
      errors++; $display("FAIL b2b_retired: got %0d want 5", retired);
    end
  endtask

  task automatic test_rst_mid_run();
    bit ok;
    prog(0, enc(LOADI, 16'h22));
    prog(1, enc(STORE, 16'd6));
    prog(2, enc(HALT, 16'd0));
    pulse_start();
    run_to_halt(ok);
    prog(0, enc(LOADI, 16'h55));
    pulse_start();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    io.dbg_addr = 4'd6; #1;
    checks++;
    if (io.dbg_rdata !== 32'h22) begin
      errors++; $display("FAIL abort_d6: got %h want 22", io.dbg_rdata);
    end
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || pc !== 4'd0 || acc !== 32'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b halted=%b pc=%0d acc=%h want 0 0 0 0",
               busy, halted, pc, acc);
    end
    pulse_start();
    checks++;
    if (retired !== 16'd0 || pc !== 4'd0) begin
      errors++;
      $display("FAIL restart_clr: retired=%0d pc=%0d want 0 0", retired, pc);
    end
    run_to_halt(ok);
    #1;
    checks++;
    if (!ok || io.dbg_rdata !== 32'h55 || retired !== 16'd3 || pc !== 4'd2) begin
      errors++;
      $display("FAIL restart_run: ok=%b d6=%h ret=%0d pc=%0d want 1 55 3 2",
               ok, io.dbg_rdata, retired, pc);
    end
  endtask

  initial begin
    io.prog_we   = 1'b0;
    io.prog_addr = '0;
    io.prog_data = '0;
    io.dbg_addr  = '0;
    test_reset();
    test_setup();
    test_add_store();
    test_brz_sub();
    test_jmp_loop();
    test_wrap();
    test_back_to_back();
    test_rst_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
